host_loader: RTL and testbench
==============================

# host_loader

Command-stream front end for the `TCAD` array: accepts a 32-bit valid/ready word stream from the host interface and produces the `init`, `run`, `host_controller` and `ex_bus` signals that `Delay`/`TCAD` consume. It assembles the wide configuration word from 32-bit beats, issues one `init` pulse per applied configuration, and converts data bursts into sequential `ex_bus` SPM writes. It issues `run` pulses with a programmable post-run hold-off. It replaces hand-driven stimulus as the stage directly upstream of `Delay`.

## Interface
Parameters:
- `HC_W`, default `` `H_C_W ``: host_controller width, covering SPM config plus PE/LSU config.
- `A_W`, default `` `A_W ``: SPM address width; must be ≤ 12.
- `EXB_W`, default `` `EX_bus ``: ex_bus width, `2 + A_W + 32`.

Ports (clocking: one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  stream word accepted when `s_valid & s_ready`.
- `s_data`  in  32  stream word (header or payload).
- `init`  out  1  one-cycle configuration strobe.
- `run`  out  1  one-cycle run strobe.
- `host_controller`  out  HC_W  last applied configuration.
- `ex_bus`  out  EXB_W  `{wen, ren, addr[A_W-1:0], data[31:0]}`.
- `busy`  out  1  high in every state except HDR.
- `err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- Header word fields:
  - `[31:28]` op: 1 = CFG, 2 = DATA, 3 = RUN; anything else is illegal.
  - `[27:16]` base address; only the low A_W bits are used.
  - `[15:0]` count N.
- States: HDR, CFG_LD, CFG_APPLY, DATA_WR, RUN_WAIT, CHK (CHK exists only with the macro).
- HDR: `s_ready=1`.
  - CFG → CFG_LD with beat counter = 0.
  - DATA, N>0 → DATA_WR. DATA, N=0 → stays in HDR, no write.
  - RUN → RUN_WAIT and `run` pulses.
  - Illegal op → set `err`, stay in HDR (the word is consumed).
- CFG_LD: accepts K = ceil(HC_W/32) beats, least-significant beat first, into an assembly register. Bits of the last beat above HC_W are discarded. After beat K → CFG_APPLY, or → CHK when the macro is on. The CFG N field is ignored.
- CFG_APPLY: `s_ready=0` for one cycle.
  - The assembly register is copied into the `host_controller` shadow and `init` = 1 in the same cycle.
  - → HDR.
  - `host_controller` is stable between applies; a partially loaded config never reaches the output.
- DATA_WR: each accepted beat i (0..N-1) produces, the next cycle, `ex_bus = {1, 0, (base+i) mod 2^A_W, beat}`.
  - Address wraps modulo 2^A_W.
  - `wen` drops to 0 in any cycle with no accepted beat. `ex_bus` data/addr hold their last values.
  - After beat N-1 → HDR, or → CHK when the macro is on.
- RUN_WAIT: `s_ready=0`. Counts N cycles after the `run` pulse, then → HDR. With N=0 it returns to HDR on the next cycle.
- `ren` in `ex_bus` is always 0.

## Timing
- Reset: state HDR, counters 0. All of `s_ready`, `init`, `run`, `host_controller`, `ex_bus`, `busy`, `err` are 0 during reset, and `s_ready` goes to 1 in the first cycle after reset.
- `rst` mid-command abandons the command: no `init`, and a partial config is never applied.
- All outputs are registered.
- `ex_bus` write appears 1 cycle after beat acceptance.
- `init` is high in the cycle after the last CFG beat is accepted (after the checksum beat when the macro is on).
- `run` is high in the cycle after the RUN header is accepted. The next header is accepted N+1 cycles after that pulse.
- Back-to-back commands: a header may be accepted in the cycle immediately after the final payload beat (DATA) or after CFG_APPLY.
- `s_valid` low mid-payload: the state and counters hold with no timeout.

## Configuration
- `HOST_LOADER_CKSUM_EN` defined:
  - Each CFG, and each DATA with N>0, is followed by one checksum beat equal to the XOR of all payload beats; CHK accepts it.
  - Mismatch sets `err`. A CFG mismatch suppresses CFG_APPLY: no `init`, and `host_controller` is unchanged. DATA writes are already issued and are not undone.
- `HOST_LOADER_CKSUM_EN` undefined: no checksum beat, CHK and the XOR accumulator are absent, and `err` reports only illegal opcodes.

## Structure
- Shared package `host_loader_pkg`:
  - op codes `OP_CFG=1`, `OP_DATA=2`, `OP_RUN=3`;
  - state enum;
  - header field bit positions;
  - `CFG_BEATS = (HC_W+31)/32`.
- Widths `H_C_W`, `A_W`, `EX_bus` come from `param_define.v`.
- One sub-module: `host_cfg_assembler`, which holds the beat counter, the assembly register and the apply-to-shadow logic. The FSM, address counter, run counter and checksum stay in `host_loader`.

## Test plan
- CFG with K beats `0x00000001, 0x00000002, …` → `init` high exactly 1 cycle after the last beat; `host_controller` low 64 bits equal `0x00000002_00000001`; `host_controller` unchanged mid-load.
- DATA header base=0x3FE, N=4 (A_W=10), beats 0xA..0xD → 4 consecutive writes at addresses 0x3FE, 0x3FF, 0x000, 0x001; `wen` drops after the last write.
- RUN N=3 then CFG header offered immediately → `run` 1 cycle; `s_ready` low until 4 cycles after the `run` pulse; then the header is accepted.
- Opcode 0xF header, then DATA N=1 → `err`=1 and stays 1; the DATA write still occurs.
- `rst` pulsed after 2 of K CFG beats, then a full CFG → no `init` from the aborted load; the subsequent CFG applies correctly.
- With `HOST_LOADER_CKSUM_EN`: CFG with a wrong checksum beat → `err`=1, no `init`, `host_controller` keeps its previous value; CFG with the correct XOR → `init` pulses.

Source files
------------

// File: rtl/host_loader_pkg.sv
// Shared definitions for the host command-stream loader: op codes, header
// field positions, FSM state encoding and the config beat-count helper.
// Widths normally come from param_define.v; defaults are provided when absent.
`ifndef H_C_W
`define H_C_W 72
`endif
`ifndef A_W
`define A_W 10
`endif
`ifndef EX_bus
`define EX_bus (2 + `A_W + 32)
`endif

package host_loader_pkg;

    // Header op codes ([31:28])
    localparam logic [3:0] OP_CFG  = 4'd1;
    localparam logic [3:0] OP_DATA = 4'd2;
    localparam logic [3:0] OP_RUN  = 4'd3;

    // Header field positions
    localparam int OP_LSB   = 28;
    localparam int OP_W     = 4;
    localparam int BASE_LSB = 16;
    localparam int CNT_LSB  = 0;
    localparam int CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_CFG_LD,
        ST_CFG_APPLY,
        ST_DATA_WR,
        ST_RUN_WAIT,
        ST_CHK
    } state_t;

    function automatic int cfg_beats(input int hc_w);
        return (hc_w + 31) / 32;
    endfunction

    localparam int CFG_BEATS = (`H_C_W + 31) / 32;

endpackage

// File: rtl/host_cfg_assembler.sv
// Assembles the wide configuration word from 32-bit beats and applies it to the shadow.
// Latency: host_controller updates the cycle after apply; beat merge is same-cycle.
// Backpressure: none internally; the caller gates beat_vld with its own handshake.
// Ports: clk/rst; clear restarts the beat counter; beat_vld/beat_dat load one beat
// (LSB beat first); apply copies the assembled word (including a beat offered in the
// same cycle) into host_controller; last_beat flags that the next beat completes it.
module host_cfg_assembler
    import host_loader_pkg::*;
#(
    parameter int HC_W  = `H_C_W,
    parameter int BEATS = CFG_BEATS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            beat_vld,
    input  logic [31:0]     beat_dat,
    input  logic            apply,
    output logic            last_beat,
    output logic [HC_W-1:0] host_controller
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]   cnt_q;
    logic [HC_W-1:0] asm_q;
    logic [HC_W-1:0] asm_d;
    logic [HC_W-1:0] hc_q;

    assign last_beat       = (cnt_q == CW'(BEATS - 1));
    assign host_controller = hc_q;

    // Merge the incoming beat bit-by-bit so bits of the final beat above HC_W
    // simply have no destination.
    always_comb begin
        asm_d = asm_q;
        for (int i = 0; i < HC_W; i++) begin
            if (beat_vld && (int'(cnt_q) == i / 32)) begin
                asm_d[i] = beat_dat[i % 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
            hc_q  <= '0;
        end else begin
            asm_q <= asm_d;
            if (clear) begin
                cnt_q <= '0;
            end else if (beat_vld) begin
                cnt_q <= last_beat ? '0 : cnt_q + CW'(1);
            end
            if (apply) begin
                hc_q <= asm_d;
            end
        end
    end

endmodule

// File: rtl/host_loader.sv
// Command-stream front end: headers/payload in, init/run strobes and ex_bus SPM writes out.
// Latency: all outputs registered; write, init and run appear 1 cycle after the causing beat.
// Backpressure: s_ready low in CFG_APPLY and RUN_WAIT; s_valid gaps simply stall payload.
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_data command stream;
// init/run strobes; host_controller config shadow; ex_bus {wen,ren,addr,data};
// busy (state != HDR); err (sticky: illegal op, or checksum mismatch).
// Optional macro HOST_LOADER_CKSUM_EN adds an XOR checksum beat after each
// CFG and each non-empty DATA command, verified in the CHK state.
`ifndef H_C_W
`define H_C_W 72
`endif
`ifndef A_W
`define A_W 10
`endif
`ifndef EX_bus
`define EX_bus (2 + `A_W + 32)
`endif

module host_loader
    import host_loader_pkg::*;
#(
    parameter int HC_W  = `H_C_W,
    parameter int A_W   = `A_W,
    parameter int EXB_W = `EX_bus
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             init,
    output logic             run,
    output logic [HC_W-1:0]  host_controller,
    output logic [EXB_W-1:0] ex_bus,
    output logic             busy,
    output logic             err
);

    state_t state_q, state_d;

    logic             accept;
    logic [OP_W-1:0]  hdr_op;
    logic [A_W-1:0]   hdr_base;
    logic [CNT_W-1:0] hdr_cnt;
    logic             cfg_last;

    // Output-process results
    logic s_ready_d, busy_d;
    logic hdr_acc, cfg_start, run_set, illegal, apply, cfg_beat, data_beat, cksum_bad;

    // Registered state / outputs
    logic             s_ready_q, busy_q, init_q, run_q, err_q;
    logic             wen_q;
    logic [A_W-1:0]   wr_addr_q;
    logic [31:0]      wr_data_q;
    logic [A_W-1:0]   addr_q;
    logic [CNT_W-1:0] left_q;
    logic [CNT_W-1:0] run_cnt_q;
`ifdef HOST_LOADER_CKSUM_EN
    logic [31:0]      xor_q;
    logic             chk_cfg_q;
    logic             cksum_ok;
`endif

    assign accept   = s_valid & s_ready_q;
    assign hdr_op   = s_data[OP_LSB +: OP_W];
    assign hdr_base = s_data[BASE_LSB +: A_W];
    assign hdr_cnt  = s_data[CNT_LSB +: CNT_W];
`ifdef HOST_LOADER_CKSUM_EN
    assign cksum_ok = (s_data == xor_q);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    case (hdr_op)
                        OP_CFG:  state_d = ST_CFG_LD;
                        OP_DATA: state_d = (hdr_cnt != '0) ? ST_DATA_WR : ST_HDR;
                        OP_RUN:  state_d = ST_RUN_WAIT;
                        default: state_d = ST_HDR;
                    endcase
                end
            end
            ST_CFG_LD: begin
                if (accept && cfg_last) begin
`ifdef HOST_LOADER_CKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_CFG_APPLY;
`endif
                end
            end
            ST_CFG_APPLY: state_d = ST_HDR;
            ST_DATA_WR: begin
                if (accept && left_q == CNT_W'(1)) begin
`ifdef HOST_LOADER_CKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_HDR;
`endif
                end
            end
            ST_RUN_WAIT: begin
                if (run_cnt_q == '0) begin
                    state_d = ST_HDR;
                end
            end
`ifdef HOST_LOADER_CKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_d = (chk_cfg_q && cksum_ok) ? ST_CFG_APPLY : ST_HDR;
                end
            end
`endif
            default: state_d = ST_HDR;
        endcase
    end

    // Output / control decode; registered below so every port is a flop.
    always_comb begin
        hdr_acc   = accept && (state_q == ST_HDR);
        cfg_start = hdr_acc && (hdr_op == OP_CFG);
        run_set   = hdr_acc && (hdr_op == OP_RUN);
        illegal   = hdr_acc && (hdr_op != OP_CFG) && (hdr_op != OP_DATA) && (hdr_op != OP_RUN);
        cfg_beat  = accept && (state_q == ST_CFG_LD);
        data_beat = accept && (state_q == ST_DATA_WR);
        cksum_bad = 1'b0;
`ifdef HOST_LOADER_CKSUM_EN
        // The shadow is only written once the checksum beat confirms the load.
        apply     = accept && (state_q == ST_CHK) && chk_cfg_q && cksum_ok;
        cksum_bad = accept && (state_q == ST_CHK) && !cksum_ok;
`else
        apply     = cfg_beat && cfg_last;
`endif
        s_ready_d = (state_d == ST_HDR) || (state_d == ST_CFG_LD) ||
                    (state_d == ST_DATA_WR) || (state_d == ST_CHK);
        busy_d    = (state_d != ST_HDR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            init_q    <= 1'b0;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
            wen_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            addr_q    <= '0;
            left_q    <= '0;
            run_cnt_q <= '0;
        end else begin
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            init_q    <= apply;
            run_q     <= run_set;
            wen_q     <= data_beat;
            if (illegal || cksum_bad) begin
                err_q <= 1'b1;
            end
            if (hdr_acc) begin
                addr_q    <= hdr_base;
                left_q    <= hdr_cnt;
                run_cnt_q <= hdr_cnt;
            end
            if (data_beat) begin
                wr_addr_q <= addr_q;
                wr_data_q <= s_data;
                addr_q    <= addr_q + A_W'(1);
                left_q    <= left_q - CNT_W'(1);
            end
            if (state_q == ST_RUN_WAIT && run_cnt_q != '0) begin
                run_cnt_q <= run_cnt_q - CNT_W'(1);
            end
        end
    end

`ifdef HOST_LOADER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_q     <= '0;
            chk_cfg_q <= 1'b0;
        end else begin
            if (hdr_acc) begin
                xor_q     <= '0;
                chk_cfg_q <= (hdr_op == OP_CFG);
            end else if (cfg_beat || data_beat) begin
                xor_q <= xor_q ^ s_data;
            end
        end
    end
`endif

    host_cfg_assembler #(
        .HC_W  (HC_W),
        .BEATS (cfg_beats(HC_W))
    ) u_cfg (
        .clk             (clk),
        .rst             (rst),
        .clear           (cfg_start),
        .beat_vld        (cfg_beat),
        .beat_dat        (s_data),
        .apply           (apply),
        .last_beat       (cfg_last),
        .host_controller (host_controller)
    );

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign init    = init_q;
    assign run     = run_q;
    assign err     = err_q;
    assign ex_bus  = {wen_q, 1'b0, wr_addr_q, wr_data_q};

endmodule

// File: tb/tb_host_loader.sv
// Directed bench for host_loader: DATA vectors from a table, hand-written
// sequences for CFG, RUN hold-off, illegal op, reset abort and checksum.
module tb_host_loader;

    localparam int HC_W  = 72;
    localparam int A_W   = 10;
    localparam int EXB_W = 2 + A_W + 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic [31:0]      s_data = '0;
    logic             s_ready;
    logic             init;
    logic             run;
    logic [HC_W-1:0]  host_controller;
    logic [EXB_W-1:0] ex_bus;
    logic             busy;
    logic             err;

    host_loader #(.HC_W(HC_W), .A_W(A_W), .EXB_W(EXB_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .init            (init),
        .run             (run),
        .host_controller (host_controller),
        .ex_bus          (ex_bus),
        .busy            (busy),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [11:0]       base;
        logic [15:0]       n;
        logic [3:0][31:0]  d;
        logic [3:0][9:0]   ea;
    } dvec_t;

    dvec_t vt [4];

    function automatic dvec_t mk(input logic [11:0] base, input logic [15:0] n,
                                 input logic [3:0][31:0] d, input logic [3:0][9:0] ea);
        dvec_t v;
        v.base = base;
        v.n    = n;
        v.d    = d;
        v.ea   = ea;
        return v;
    endfunction

    function automatic logic [31:0] hdr(input logic [3:0] op, input logic [11:0] base,
                                        input logic [15:0] n);
        return {op, base, n};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and return #1 after the edge that accepted it.
    task automatic push(input logic [31:0] w);
        int t;
        s_valid = 1'b1;
        s_data  = w;
        t = 0;
        while (!s_ready && t < 64) begin
            step();
            t++;
        end
        if (t >= 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: word %0h not accepted within %0d cycles", w, t);
        end
        step();
        s_valid = 1'b0;
    endtask

    // Full CFG command; returns #1 after the last accepted word.
    task automatic send_cfg(input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] ck);
        push(hdr(4'd1, 12'h0, 16'd0));
        push(b0);
        push(b1);
        push(b2);
`ifdef HOST_LOADER_CKSUM_EN
        push(ck);
`else
        if (ck == 32'h0) s_data = 32'h0;
`endif
    endtask

    initial begin
        logic [31:0] x;
        int k;

        vt[0] = mk(12'h3FE, 16'd4, {32'hD, 32'hC, 32'hB, 32'hA},
                   {10'h001, 10'h000, 10'h3FF, 10'h3FE});
        vt[1] = mk(12'hC05, 16'd2, {32'h0, 32'h0, 32'h22, 32'h11},
                   {10'h0, 10'h0, 10'h006, 10'h005});
        vt[2] = mk(12'h100, 16'd1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                   {10'h0, 10'h0, 10'h0, 10'h100});
        vt[3] = mk(12'h050, 16'd3, {32'h0, 32'h3, 32'h2, 32'h1},
                   {10'h0, 10'h052, 10'h051, 10'h050});

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_s_ready", s_ready, 0);
        check("rst_strobes", {init, run, busy, err}, 0);
        check("rst_hc", host_controller, 0);
        check("rst_ex_bus", ex_bus, 0);
        rst = 1'b0;
        step();
        check("s_ready_after_rst", s_ready, 1);

        // CFG: three beats, bits above HC_W in the last beat are dropped
        push(hdr(4'd1, 12'h0, 16'd0));
        check("cfg_busy", busy, 1);
        push(32'h1);
        check("cfg_mid_hc0", host_controller, 0);
        push(32'h2);
        check("cfg_mid_hc1", host_controller, 0);
        check("cfg_mid_init", init, 0);
        push(32'hFFFF_FF03);
`ifdef HOST_LOADER_CKSUM_EN
        push(32'h1 ^ 32'h2 ^ 32'hFFFF_FF03);
`endif
        check("cfg_init", init, 1);
        check("cfg_hc", host_controller, 72'h03_00000002_00000001);
        check("cfg_apply_ready", s_ready, 0);
        step();
        check("cfg_init_drop", init, 0);
        check("cfg_back_ready", s_ready, 1);

        // DATA table
        for (int v = 0; v < 4; v++) begin
            push(hdr(4'd2, vt[v].base, vt[v].n));
            x = '0;
            for (int i = 0; i < int'(vt[v].n); i++) begin
                push(vt[v].d[i]);
                x = x ^ vt[v].d[i];
                check($sformatf("data_wr_v%0d_b%0d", v, i), ex_bus,
                      {1'b1, 1'b0, vt[v].ea[i], vt[v].d[i]});
            end
`ifdef HOST_LOADER_CKSUM_EN
            push(x);
`endif
            step();
            check($sformatf("data_wen_drop_v%0d", v), ex_bus[EXB_W-1], 0);
            check($sformatf("data_hold_v%0d", v), ex_bus[EXB_W-3:0],
                  {vt[v].ea[vt[v].n-1], vt[v].d[vt[v].n-1]});
        end

        // DATA with N=0: no write, stays in HDR
        push(hdr(4'd2, 12'h010, 16'd0));
        check("data_n0_busy", busy, 0);
        check("data_n0_ready", s_ready, 1);
        check("data_n0_wen", ex_bus[EXB_W-1], 0);

        // RUN N=3 with a CFG header waiting
        push(hdr(4'd3, 12'h0, 16'd3));
        check("run_pulse", run, 1);
        check("run_ready_low", s_ready, 0);
        s_valid = 1'b1;
        s_data  = hdr(4'd1, 12'h0, 16'd0);
        step();
        check("run_one_cycle", run, 0);
        k = 1;
        while (!s_ready && k < 20) begin
            step();
            k++;
        end
        check("run_holdoff", k, 4);
        step();
        s_valid = 1'b0;
        check("run_hdr_taken", busy, 1);
        push(32'h11);
        check("cfg2_mid_hc", host_controller, 72'h03_00000002_00000001);
        push(32'h22);
        push(32'h33);
`ifdef HOST_LOADER_CKSUM_EN
        push(32'h11 ^ 32'h22 ^ 32'h33);
`endif
        check("cfg2_init", init, 1);
        check("cfg2_hc", host_controller, 72'h33_00000022_00000011);

        // RUN N=0 returns next cycle
        push(hdr(4'd3, 12'h0, 16'd0));
        check("run0_pulse", run, 1);
        step();
        check("run0_ready", s_ready, 1);

        // Illegal op then DATA N=1
        push(32'hF000_0000);
        check("illegal_err", err, 1);
        check("illegal_busy", busy, 0);
        push(hdr(4'd2, 12'h020, 16'd1));
        push(32'h55);
        check("illegal_then_wr", ex_bus, {1'b1, 1'b0, 10'h020, 32'h55});
`ifdef HOST_LOADER_CKSUM_EN
        push(32'h55);
`endif
        check("err_sticky", err, 1);

        // Reset after two of three CFG beats
        push(hdr(4'd1, 12'h0, 16'd0));
        push(32'hAA);
        push(32'hBB);
        rst = 1'b1;
        step();
        check("abort_init", init, 0);
        check("abort_err_clr", err, 0);
        check("abort_hc", host_controller, 0);
        step();
        rst = 1'b0;
        step();
        check("abort_ready", s_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("abort_no_init_%0d", i), init, 0);
        end
        send_cfg(32'h1, 32'h2, 32'h3, 32'h1 ^ 32'h2 ^ 32'h3);
        check("after_abort_init", init, 1);
        check("after_abort_hc", host_controller, 72'h03_00000002_00000001);

`ifdef HOST_LOADER_CKSUM_EN
        send_cfg(32'h5, 32'h6, 32'h7, 32'h0);
        check("ck_bad_err", err, 1);
        check("ck_bad_init", init, 0);
        step();
        check("ck_bad_hc", host_controller, 72'h03_00000002_00000001);
        send_cfg(32'h5, 32'h6, 32'h7, 32'h5 ^ 32'h6 ^ 32'h7);
        check("ck_good_init", init, 1);
        check("ck_good_hc", host_controller, 72'h07_00000006_00000005);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
